if_prefetch_unit: RTL

Parametrised instruction-fetch stage with a prefetch queue, the next generation of the pipeline's IF stage. It owns the architectural fetch PC, reads a synchronous 1-cycle-latency instruction ROM, buffers up to DEPTH fetched words with their PCs, and presents them to decode through a valid/accept handshake. JR/J/branch redirects flush the queue and kill any in-flight ROM read.

---
 rtl/if_prefetch_unit.sv | 139 +++++++++++++
 1 files changed

// File: rtl/if_prefetch_unit.sv
// Instruction-fetch stage with a prefetch queue in front of a 1-cycle synchronous ROM.
// Owns the fetch PC, issues reads on credit, and flushes on JR/J/branch redirects.
module if_prefetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          ROM_AW   = 6,
    parameter int          DEPTH    = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              Z,
    input  logic              J,
    input  logic              JR,
    input  logic [31:0]       JumpAddr,
    input  logic [31:0]       JrAddr,
    input  logic [31:0]       BranchAddr,
    input  logic              PC_IFWrite,
    output logic              rom_en,
    output logic [ROM_AW-1:0] rom_addr,
    input  logic [31:0]       rom_data,
    output logic              inst_valid,
    output logic [31:0]       Instruction_if,
    output logic [31:0]       PC,
    output logic [31:0]       NextPC_if
);

    localparam int              PTR_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int              CNT_W     = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W:0]   DEPTH_EXT = (CNT_W + 1)'(DEPTH);
    localparam logic [31:0]      WORD_MASK = 32'hFFFF_FFFC;

    logic [31:0]      fetch_pc_r;
    logic             inflight_r;
    logic [31:0]      inflight_pc_r;
    logic [31:0]      instr_mem_r [DEPTH];
    logic [31:0]      pc_mem_r    [DEPTH];
    logic [PTR_W-1:0] rd_ptr_r;
    logic [PTR_W-1:0] wr_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             primed_r;

    logic             redirect_s;
    logic [31:0]      target_s;
    logic             valid_s;
    logic             pop_s;
    logic             push_s;
    logic             issue_s;
    logic [CNT_W:0]   occupancy_s;
    logic [CNT_W:0]   limit_s;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
        if (ptr == LAST_PTR) begin
            return PTR_W'(0);
        end else begin
            return ptr + PTR_W'(1);
        end
    endfunction

    // Redirect target selection, JR beats J beats branch; targets are word aligned.
    always_comb begin
        redirect_s = JR | J | Z;
        if (JR) begin
            target_s = JrAddr & WORD_MASK;
        end else if (J) begin
            target_s = JumpAddr & WORD_MASK;
        end else if (Z) begin
            target_s = BranchAddr & WORD_MASK;
        end else begin
            target_s = fetch_pc_r;
        end
    end

    // Credit check: a new read is allowed only if its response is sure to find a free slot.
    always_comb begin
        valid_s     = (count_r != CNT_W'(0));
        pop_s       = PC_IFWrite & valid_s;
        push_s      = inflight_r & ~redirect_s;
        occupancy_s = {1'b0, count_r} + (CNT_W + 1)'(inflight_r);
        limit_s     = DEPTH_EXT + (CNT_W + 1)'(pop_s);
        if (reset || redirect_s) begin
            issue_s = 1'b0;
        end else begin
            issue_s = (occupancy_s < limit_s);
        end
    end

    // Fetch PC, in-flight tracking and queue storage.
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc_r    <= RESET_PC;
            inflight_r    <= 1'b0;
            inflight_pc_r <= 32'd0;
            rd_ptr_r      <= PTR_W'(0);
            wr_ptr_r      <= PTR_W'(0);
            count_r       <= CNT_W'(0);
            primed_r      <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                instr_mem_r[i] <= 32'd0;
                pc_mem_r[i]    <= 32'd0;
            end
        end else if (redirect_s) begin
            // Flush: the outstanding response, if any, is dropped because inflight clears.
            fetch_pc_r <= target_s;
            inflight_r <= 1'b0;
            rd_ptr_r   <= PTR_W'(0);
            wr_ptr_r   <= PTR_W'(0);
            count_r    <= CNT_W'(0);
        end else begin
            inflight_r <= issue_s;
            if (issue_s) begin
                inflight_pc_r <= fetch_pc_r;
                fetch_pc_r    <= fetch_pc_r + 32'd4;
            end
            if (push_s) begin
                instr_mem_r[wr_ptr_r] <= rom_data;
                pc_mem_r[wr_ptr_r]    <= inflight_pc_r;
                wr_ptr_r              <= ptr_inc(wr_ptr_r);
                primed_r              <= 1'b1;
            end
            if (pop_s) begin
                rd_ptr_r <= ptr_inc(rd_ptr_r);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Until the first word lands after reset the head reads as all zeros, NextPC_if included.
    assign rom_en         = issue_s;
    assign rom_addr       = fetch_pc_r[ROM_AW+1:2];
    assign inst_valid     = valid_s;
    assign Instruction_if = instr_mem_r[rd_ptr_r];
    assign PC             = pc_mem_r[rd_ptr_r];
    assign NextPC_if      = primed_r ? (pc_mem_r[rd_ptr_r] + 32'd4) : 32'd0;

endmodule
